// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: segment bit order and the
// active-high 0-F glyph set.
package seven_seg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Indexed by nibble value, bits {g,f,e,d,c,b,a}, 1 = segment lit
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational nibble to active-high seven-segment glyph decoder.
module hex_seg_lut
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_TABLE[nibble];
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver: frame-coherent shadow registers,
// leading-zero blanking, anti-ghosting guard and registered polarity outputs.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD          = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   pend_val, disp_val;
    logic [DIGITS-1:0]     pend_dp, disp_dp;
    logic                  slot_end, frame_end, in_guard;

    assign slot_end  = (cnt == LAST_CNT);
    assign frame_end = slot_end && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            disp_val <= '0;
            disp_dp  <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp;
            end
            // A load on the boundary cycle bypasses pending straight into the frame
            if (frame_end) begin
                disp_val <= load ? value : pend_val;
                disp_dp  <= load ? dp    : pend_dp;
            end
        end
    end

    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (cnt < CW'(GUARD));
        end
    endgenerate

    logic [3:0]        cur_nib;
    logic              cur_dp, cur_blank, all_zero;
    logic [DIGITS-1:0] blank_mask, dig_sel;
    logic [6:0]        lut_glyph, seg_hi;
    logic              dp_hi;
    logic [DIGITS-1:0] dig_hi;

    always_comb begin
        cur_nib    = '0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        all_zero   = 1'b1;
        blank_mask = '0;
        dig_sel    = '0;
        // Walk from the most significant digit down, accumulating "all zero so far"
        for (int unsigned k = 0; k < DIGITS; k++) begin
            all_zero = all_zero & (disp_val[4*(DIGITS-1-k) +: 4] == 4'h0);
            blank_mask[DIGITS-1-k] = blank_lz & all_zero & (k != DIGITS - 1);
        end
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (IW'(k) == idx) begin
                cur_nib    = disp_val[4*k +: 4];
                cur_dp     = disp_dp[k];
                cur_blank  = blank_mask[k];
                dig_sel[k] = 1'b1;
            end
        end
    end

    hex_seg_lut u_lut (
        .nibble (cur_nib),
        .glyph  (lut_glyph)
    );

    always_comb begin
        seg_hi = cur_blank ? SEG_BLANK : lut_glyph;
        dp_hi  = cur_dp;
        dig_hi = dig_sel;
        if (in_guard) begin
            seg_hi = SEG_BLANK;
            dp_hi  = 1'b0;
            dig_hi = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= {7{SEG_ACTIVE_LOW}};
            seg_dp     <= SEG_ACTIVE_LOW;
            dig_en     <= {DIGITS{DIG_ACTIVE_LOW}};
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_hi ^ {7{SEG_ACTIVE_LOW}};
            seg_dp     <= dp_hi ^ SEG_ACTIVE_LOW;
            dig_en     <= dig_hi ^ {DIGITS{DIG_ACTIVE_LOW}};
            frame_done <= frame_end;
        end
    end

endmodule
